// File: rtl/pic_instr_sequencer_if.sv
// Bus between the PIC16 instruction sequencer and its ALU/regfile/PC neighbours.
// No handshake: instr is sampled on the clock edge that ends Q4, and the
// zero/bit-test results are consumed combinationally during Q4.
interface pic_instr_sequencer_if;
  logic [13:0] instr;
  logic        alu_out_z;
  logic        alu_bit_test_res;
  logic [1:0]  q_phase;
  logic [3:0]  alu_op;
  logic        lf_sel_lit;
  logic [7:0]  literal;
  logic [6:0]  f_addr;
  logic [2:0]  bit_sel;
  logic        alu_d;
  logic        alu_d_wr_en;
  logic        alu_status_wr_en;
  logic        f_rd_en;
  logic        bit_wr_en;
  logic        bit_val;
  logic        pc_inc;
  logic        pc_load;
  logic        stack_push;
  logic        stack_pop;

  modport master (
    input  instr, alu_out_z, alu_bit_test_res,
    output q_phase, alu_op, lf_sel_lit, literal, f_addr, bit_sel, alu_d,
           alu_d_wr_en, alu_status_wr_en, f_rd_en, bit_wr_en, bit_val,
           pc_inc, pc_load, stack_push, stack_pop
  );

  modport slave (
    output instr, alu_out_z, alu_bit_test_res,
    input  q_phase, alu_op, lf_sel_lit, literal, f_addr, bit_sel, alu_d,
           alu_d_wr_en, alu_status_wr_en, f_rd_en, bit_wr_en, bit_val,
           pc_inc, pc_load, stack_push, stack_pop
  );
endinterface

// File: rtl/pic_instr_sequencer.sv
// PIC16F instruction sequencer: Q1-Q4 phase generator, instruction register,
// decoder and PC/stack control with one flushed cycle after branches and skips.
module pic_instr_sequencer (
  input  logic                         clk,
  input  logic                         rst,
  pic_instr_sequencer_if.master        bus
);

  localparam logic [3:0] ALU_NOP    = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_CLR    = 4'd3;
  localparam logic [3:0] ALU_COM    = 4'd4;
  localparam logic [3:0] ALU_DEC    = 4'd5;
  localparam logic [3:0] ALU_INC    = 4'd6;
  localparam logic [3:0] ALU_OR     = 4'd7;
  localparam logic [3:0] ALU_PASSLF = 4'd8;
  localparam logic [3:0] ALU_PASSW  = 4'd9;
  localparam logic [3:0] ALU_RLF    = 4'd10;
  localparam logic [3:0] ALU_RRF    = 4'd11;
  localparam logic [3:0] ALU_SUB    = 4'd12;
  localparam logic [3:0] ALU_SWAPF  = 4'd13;
  localparam logic [3:0] ALU_XOR    = 4'd14;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_t;

  phase_t      r_phase;
  phase_t      w_phase_next;
  logic [13:0] r_ir;
  logic        r_flush;

  logic [3:0]  w_op;
  logic        w_lit;
  logic        w_d;
  logic        w_st;
  logic        w_fr;
  logic        w_wr;
  logic        w_bw;
  logic        w_bv;
  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_br;
  logic        w_skz;
  logic        w_skb1;
  logic        w_skb0;
  logic        w_byte;

  logic        w_act;
  logic        w_skip;
  logic        w_flush_next;
  logic        w_q2;
  logic        w_q4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= Q1;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      Q1:      w_phase_next = Q2;
      Q2:      w_phase_next = Q3;
      Q3:      w_phase_next = Q4;
      Q4:      w_phase_next = Q1;
      default: w_phase_next = Q1;
    endcase
  end

  // Reset leaves flush set so the garbage cycle before the first fetch is a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir    <= 14'h0000;
      r_flush <= 1'b1;
    end else if (r_phase == Q4) begin
      r_ir    <= bus.instr;
      r_flush <= w_flush_next;
    end
  end

  always_comb begin
    w_op   = ALU_NOP;
    w_lit  = 1'b0;
    w_d    = 1'b0;
    w_st   = 1'b0;
    w_fr   = 1'b0;
    w_wr   = 1'b0;
    w_bw   = 1'b0;
    w_bv   = 1'b0;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_load = 1'b0;
    w_br   = 1'b0;
    w_skz  = 1'b0;
    w_skb1 = 1'b0;
    w_skb0 = 1'b0;
    w_byte = 1'b0;

    casez (r_ir[13:8])
      6'b000000: begin
        if (r_ir[7]) begin
          w_op = ALU_PASSW;
          w_d  = 1'b1;
          w_wr = 1'b1;
        end else if (r_ir == 14'h0008 || r_ir == 14'h0009) begin
          w_pop = 1'b1;
          w_br  = 1'b1;
        end
      end
      6'b000001: begin
        w_op = ALU_CLR;
        w_d  = r_ir[7];
        w_wr = 1'b1;
        w_st = 1'b1;
      end
      6'b000010: begin w_op = ALU_SUB;    w_byte = 1'b1; end
      6'b000011: begin w_op = ALU_DEC;    w_byte = 1'b1; end
      6'b000100: begin w_op = ALU_OR;     w_byte = 1'b1; end
      6'b000101: begin w_op = ALU_AND;    w_byte = 1'b1; end
      6'b000110: begin w_op = ALU_XOR;    w_byte = 1'b1; end
      6'b000111: begin w_op = ALU_ADD;    w_byte = 1'b1; end
      6'b001000: begin w_op = ALU_PASSLF; w_byte = 1'b1; end
      6'b001001: begin w_op = ALU_COM;    w_byte = 1'b1; end
      6'b001010: begin w_op = ALU_INC;    w_byte = 1'b1; end
      6'b001100: begin w_op = ALU_RRF;    w_byte = 1'b1; end
      6'b001101: begin w_op = ALU_RLF;    w_byte = 1'b1; end
      6'b001110: begin w_op = ALU_SWAPF;  w_byte = 1'b1; end
      6'b001011, 6'b001111: begin
        w_op  = r_ir[10] ? ALU_INC : ALU_DEC;
        w_d   = r_ir[7];
        w_fr  = 1'b1;
        w_wr  = 1'b1;
        w_skz = 1'b1;
      end
      6'b0100??: begin w_fr = 1'b1; w_bw = 1'b1; end
      6'b0101??: begin w_fr = 1'b1; w_bw = 1'b1; w_bv = 1'b1; end
      6'b0110??: begin w_fr = 1'b1; w_skb0 = 1'b1; end
      6'b0111??: begin w_fr = 1'b1; w_skb1 = 1'b1; end
      6'b100???: begin w_push = 1'b1; w_load = 1'b1; w_br = 1'b1; end
      6'b101???: begin w_load = 1'b1; w_br = 1'b1; end
      6'b1100??: begin w_op = ALU_PASSLF; w_lit = 1'b1; w_wr = 1'b1; end
      6'b1101??: begin
        w_op  = ALU_PASSLF;
        w_lit = 1'b1;
        w_wr  = 1'b1;
        w_pop = 1'b1;
        w_br  = 1'b1;
      end
      6'b111000: begin w_op = ALU_OR;  w_lit = 1'b1; w_wr = 1'b1; w_st = 1'b1; end
      6'b111001: begin w_op = ALU_AND; w_lit = 1'b1; w_wr = 1'b1; w_st = 1'b1; end
      6'b111010: begin w_op = ALU_XOR; w_lit = 1'b1; w_wr = 1'b1; w_st = 1'b1; end
      6'b11110?: begin w_op = ALU_SUB; w_lit = 1'b1; w_wr = 1'b1; w_st = 1'b1; end
      6'b11111?: begin w_op = ALU_ADD; w_lit = 1'b1; w_wr = 1'b1; w_st = 1'b1; end
      default: ;
    endcase

    // Byte-oriented file ops share operand/destination handling; only SWAPF leaves status alone.
    if (w_byte) begin
      w_d  = r_ir[7];
      w_fr = 1'b1;
      w_wr = 1'b1;
      w_st = (w_op != ALU_SWAPF);
    end
  end

  assign w_act        = ~r_flush;
  assign w_q2         = (r_phase == Q2);
  assign w_q4         = (r_phase == Q4);
  assign w_skip       = (w_skz & bus.alu_out_z) |
                        (w_skb1 & bus.alu_bit_test_res) |
                        (w_skb0 & ~bus.alu_bit_test_res);
  assign w_flush_next = w_act & (w_br | w_skip);

  assign bus.q_phase          = r_phase;
  assign bus.alu_op           = w_op;
  assign bus.lf_sel_lit       = w_lit;
  assign bus.literal          = r_ir[7:0];
  assign bus.f_addr           = r_ir[6:0];
  assign bus.bit_sel          = r_ir[9:7];
  assign bus.alu_d            = w_d;
  assign bus.bit_val          = w_bv;
  assign bus.f_rd_en          = w_q2 & w_act & w_fr;
  assign bus.alu_d_wr_en      = w_q4 & w_act & w_wr;
  assign bus.alu_status_wr_en = w_q4 & w_act & w_st;
  assign bus.bit_wr_en        = w_q4 & w_act & w_bw;
  assign bus.pc_load          = w_q4 & w_act & w_load;
  assign bus.pc_inc           = w_q4 & ~(w_act & w_load);
  assign bus.stack_push       = w_q4 & w_act & w_push;
  assign bus.stack_pop        = w_q4 & w_act & w_pop;

endmodule
